fft_frame_seq: RTL

- Sequencer for the 1024-point pipelined streaming FFT core in the power-spectrum path.
- On a trigger it runs a burst of NUM_FRAMES transforms. For each frame it waits until the input FIFO holds a full frame, pulses start, streams samples into the core under rfd, then counts the unloaded output beats.
- Sits between the sample FIFO and the FFT wrapper. It reports frame and burst completion to the downstream accumulator and flags underflow and timeout faults.

---
 rtl/fft_frame_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fft_frame_seq.sv
// Burst sequencer for the streaming FFT core. It waits for a full frame in the FIFO,
// starts the core, feeds it under rfd, counts the output beats and flags faults.
module fft_frame_seq #(
    parameter int NFFT    = 1024,
    parameter int IDX_W   = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [IDX_W:0]   fifo_count,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             fft_start,
    input  logic             fft_rfd,
    input  logic             fft_dv,
    input  logic             fft_done,
    output logic             seq_busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             frame_done,
    output logic             burst_done,
    output logic             err_underflow,
    output logic             err_timeout
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_START,
        S_LOAD,
        S_WAIT_OUT,
        S_UNLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
    logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] nf_q, nf_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             fft_start_q, fft_start_d;
    logic             seq_busy_q, seq_busy_d;
    logic             frame_done_q, frame_done_d;
    logic             burst_done_q, burst_done_d;
    logic             err_uf_q, err_uf_d;
    logic             err_to_q, err_to_d;
    logic             rd_req;
    logic             timeout_hit;
    logic             unused_done;

    // Done from the core is informational only; sequencing relies on beat counting.
    assign unused_done = fft_done;

    // The FIFO is first-word-fall-through, so the strobe must track rfd in the same cycle.
    assign rd_req      = (state_q == S_LOAD) && fft_rfd && !fifo_empty;
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        to_cnt_d     = to_cnt_q;
        nf_d         = nf_q;
        frame_cnt_d  = frame_cnt_q;
        fft_start_d  = 1'b0;
        frame_done_d = 1'b0;
        burst_done_d = 1'b0;
        err_uf_d     = err_uf_q;
        err_to_d     = err_to_q;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    nf_d        = (num_frames == '0) ? CNT_W'(1) : num_frames;
                    frame_cnt_d = '0;
                    err_uf_d    = 1'b0;
                    err_to_d    = 1'b0;
                    state_d     = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (fifo_count >= (IDX_W+1)'(NFFT)) begin
                    fft_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                load_cnt_d = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                if (fft_rfd && fifo_empty) begin
                    err_uf_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (rd_req) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == IDX_W'(NFFT - 1)) begin
                        to_cnt_d = '0;
                        state_d  = S_WAIT_OUT;
                    end
                end
            end
            S_WAIT_OUT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (timeout_hit) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (fft_dv) begin
                    beat_cnt_d = IDX_W'(1);
                    state_d    = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A frame that completes on the timeout cycle is still counted as good.
                if (fft_dv && beat_cnt_q == IDX_W'(NFFT - 1)) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    if (frame_cnt_d == nf_q) begin
                        burst_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end else if (timeout_hit) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (fft_dv) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        seq_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            to_cnt_q     <= '0;
            nf_q         <= CNT_W'(1);
            frame_cnt_q  <= '0;
            fft_start_q  <= 1'b0;
            seq_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            burst_done_q <= 1'b0;
            err_uf_q     <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            to_cnt_q     <= to_cnt_d;
            nf_q         <= nf_d;
            frame_cnt_q  <= frame_cnt_d;
            fft_start_q  <= fft_start_d;
            seq_busy_q   <= seq_busy_d;
            frame_done_q <= frame_done_d;
            burst_done_q <= burst_done_d;
            err_uf_q     <= err_uf_d;
            err_to_q     <= err_to_d;
        end
    end

    assign fifo_rd_en    = rd_req;
    assign fft_start     = fft_start_q;
    assign seq_busy      = seq_busy_q;
    assign frame_cnt     = frame_cnt_q;
    assign frame_done    = frame_done_q;
    assign burst_done    = burst_done_q;
    assign err_underflow = err_uf_q;
    assign err_timeout   = err_to_q;
endmodule
